// File: rtl/decoder_4to16.sv
// decoder_4to16: registered one-hot decoder; clk/rst(async), enable, in[IN_W] -> out[OUT_W] one-hot, out_valid = registered enable
module decoder_4to16 #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
);
    if (OUT_W != 2**IN_W) begin : g_bad_width
        $error("OUT_W must equal 2**IN_W");
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out       <= enable ? {{(OUT_W-1){1'b0}}, 1'b1} << in : '0;
            out_valid <= enable;
        end
    always @(posedge clk)
        if (!rst && enable) assert (!$isunknown(in));
endmodule

// File: tb/tb_decoder_4to16.sv
// tb_decoder_4to16: directed and randomized checks of decoder_4to16 against an arithmetic power-of-two model
module tb_decoder_4to16;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  in = 4'd0;
    logic [15:0] out;
    logic        out_valid;
    int          checks = 0;
    int          errors = 0;

    decoder_4to16 dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .in(in),
        .out(out),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic en, input int idx);
        int p = 1;
        if (!en) return 32'd0;
        repeat (idx) p = p * 2;
        return 32'(p);
    endfunction

    task automatic step(input logic en, input logic [3:0] idx, input string tag);
        enable = en;
        in = idx;
        @(posedge clk);
        #1;
        chk(tag, 32'(out), model(en, int'(idx)));
        chk({tag, "_valid"}, 32'(out_valid), 32'(en));
        chk({tag, "_pop"}, 32'($countones(out)), en ? 32'd1 : 32'd0);
    endtask

    initial begin
        enable = 1'b1;
        in = 4'd5;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out", 32'(out), 32'd0);
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_held_out", 32'(out), 32'd0);
            chk("rst_held_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release_out", 32'(out), 32'h0020);
        chk("rst_release_valid", 32'(out_valid), 32'd1);

        step(1'b0, 4'd0, "dis0");
        step(1'b0, 4'd0, "dis0");
        step(1'b0, 4'd1, "dis1");
        step(1'b0, 4'd1, "dis1");

        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), "sweep");

        step(1'b1, 4'd9, "tog1");
        step(1'b0, 4'd9, "tog0");
        step(1'b1, 4'd9, "tog1b");

        for (int i = 0; i < 12; i++) step(1'b1, 4'(i), "sweep2");
        enable = 1'b1;
        in = 4'd12;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        #1 rst = 1'b0;
        for (int i = 12; i < 16; i++) step(1'b1, 4'(i), "resume");

        for (int i = 0; i < 10; i++) step(1'b1, (i % 2 == 0) ? 4'd0 : 4'd15, "extreme");

        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decoder_4to16.md
Name: decoder_4to16

Overview:
Registered 4-to-16 one-hot decoder with active-high enable. It converts a 4-bit binary index into a 16-bit one-hot word, for use as a chip-select or register-select generator in the COA datapath. The output is registered on the clock so downstream select logic sees a glitch-free one-hot word. When the block is disabled or in reset, the output is all-zeros.

Parameters:
- IN_W, 4, index width in bits.
- OUT_W, 16, output width; must equal 2**IN_W (elaboration error otherwise).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- enable, input, 1, active-high decode enable.
- in, input, IN_W (4), binary index to decode.
- out, output, OUT_W (16), registered one-hot (or all-zero) decode result.
- out_valid, output, 1, registered copy of enable; high when out holds a decoded one-hot word.

Behaviour:
- Reset is asynchronous and active-high: while rst=1, out=16'h0000 and out_valid=0, independent of clk.
- Reset release is synchronous in effect: the first update happens on the first rising clk edge with rst=0.
- On each rising clk edge with rst=0:
  - out <= enable ? (1 << in) : 16'h0000
  - out_valid <= enable
- Latency is exactly 1 clock from in/enable to out/out_valid. There is no handshake and no stall; a new index is accepted every cycle.
- One-hot invariant: whenever out_valid=1, exactly one bit of out is set, at bit position in (bit 0 = index 0, bit 15 = index 15). Whenever out_valid=0, out=0.
- Full range: all indices 0..15 decode, with no reserved codes. Index 15 gives 16'h8000 and index 0 gives 16'h0001.
- Enable low masks the output. Changes on in while enable=0 must not affect out, which stays 0.
- Simultaneous enable rise and index change: the value sampled at the edge is decoded; there is no memory of earlier indices.
- Asserting rst mid-operation clears out and out_valid immediately, without waiting for a clock edge.
- X/Z on in while enable=1 may propagate to out. Simulation should flag it with an assertion.
- There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: assert rst with enable=1, in=4'd5 -> out=16'h0000 and out_valid=0 immediately and for every cycle rst is held. Release rst -> the next edge gives out=16'h0020 and out_valid=1.
- Disabled: enable=0, in=4'd0 then in=4'd1, 2 cycles each -> out=16'h0000 and out_valid=0 throughout.
- Sweep: enable=1, in=0..15 one per cycle -> one cycle later out=16'h0001, 16'h0002, 16'h0004 … 16'h4000, 16'h8000. Each output is checked equal to 1<<in and has popcount 1.
- Enable toggling: in=4'd9, enable 1,0,1 on successive cycles -> out=16'h0200, 16'h0000, 16'h0200 with 1-cycle lag. out_valid follows 1,0,1.
- Async reset mid-stream: during the sweep at in=4'd12, pulse rst between clock edges -> out drops to 16'h0000 within the same cycle. After release, decoding resumes with the next sampled index.
- Back-to-back extremes: in alternating 4'd0 and 4'd15 every cycle with enable=1 -> out alternates 16'h0001 and 16'h8000 with no cycle showing zero or two bits set.
